// File: rtl/npu_chain_sequencer.sv
// Feeds job vectors into a PE row with per-PE skew and tracks each slot to the chain tail.
// Optional head bias is built when NPU_SEQ_BIAS_EN is defined.
module npu_chain_sequencer #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         cfg_len,
`ifdef NPU_SEQ_BIAS_EN
  input  logic [DATA_W-1:0]        cfg_bias,
`endif
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DATA_W-1:0]   in_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [ROWS-1:0]          pe_enable,
  output logic [ROWS*DATA_W-1:0]   pe_self_in,
  output logic [DATA_W-1:0]        pe_sum_head,
  input  logic [DATA_W-1:0]        arr_sum_tail
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic             busy_q, done_q, in_ready_q, out_valid_q, out_last_q;
  logic [ROWS:0]    vld_q, last_q;
  logic             acc, acc_last;

  assign acc      = in_valid & in_ready_q;
  assign acc_last = acc & ((cnt_q + LEN_W'(1)) == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q <= cfg_len;
            cnt_q <= '0;
            if (cfg_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= RUN;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (acc) begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (acc_last) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Tracker empties the cycle the final result is on the output.
          if (~|vld_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      vld_q       <= {vld_q[ROWS-1:0], acc};
      last_q      <= {last_q[ROWS-1:0], acc_last};
      out_valid_q <= vld_q[ROWS];
      out_last_q  <= last_q[ROWS];
    end
  end

  for (genvar k = 0; k < ROWS; k++) begin : g_skew
    logic [DATA_W-1:0] sk_q [0:k];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= k; j++) sk_q[j] <= '0;
      end else begin
        sk_q[0] <= acc ? in_data[k*DATA_W +: DATA_W] : '0;
        for (int j = 1; j <= k; j++) sk_q[j] <= sk_q[j-1];
      end
    end

    assign pe_self_in[k*DATA_W +: DATA_W] = sk_q[k];
  end

`ifdef NPU_SEQ_BIAS_EN
  logic [DATA_W-1:0] bias_q, bias_s1_q, head_q;

  // Bias reaches PE0's sum_in while PE0 is summing the element it latched for the same slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_q    <= '0;
      bias_s1_q <= '0;
      head_q    <= '0;
    end else begin
      if (state_q == IDLE && start) bias_q <= cfg_bias;
      bias_s1_q <= acc ? bias_q : '0;
      head_q    <= bias_s1_q;
    end
  end

  assign pe_sum_head = head_q;
`else
  assign pe_sum_head = '0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = arr_sum_tail;
  assign pe_enable = {ROWS{busy_q}};
endmodule
